// File: rtl/prince_cms_pkg.sv
// rtl/prince_cms_pkg.sv - shared constants and helpers for the masked PRINCE S-box compress stage
package prince_cms_pkg;

  // Component shares per S-box output bit.
  localparam int NCOMP = 8;

  // Bits per S-box nibble.
  localparam int NIBBLE = 4;

  // Components [0, SHARE_SPLIT) fold into share 0, [SHARE_SPLIT, NCOMP) into share 1.
  localparam int SHARE_SPLIT = 4;

  // PRINCE S-box, nibble i holds S(i): B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4.
  localparam logic [63:0] PRINCE_SBOX = 64'h4D5E_0876_19CA_23FB;

  // Flat bit position of component k for S-box s, output bit b.
  function automatic int comp_idx(input int s, input int b, input int k);
    return (s * NIBBLE + b) * NCOMP + k;
  endfunction

  // Unmasked S-box lookup, used by the bench as a reference.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = PRINCE_SBOX;
    return tbl[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/prince_bit_compress.sv
// rtl/prince_bit_compress.sv - folds 8 registered component shares of one bit into 2 refreshed shares
module prince_bit_compress
  import prince_cms_pkg::*;
(
  input  logic [NCOMP-1:0] comp,
  input  logic             r,
  output logic             sh0,
  output logic             sh1
);

  // Both halves get the same fresh bit so the pair stays a valid 2-sharing.
  assign sh0 = (^comp[SHARE_SPLIT-1:0]) ^ r;
  assign sh1 = (^comp[NCOMP-1:SHARE_SPLIT]) ^ r;

endmodule

// File: rtl/prince_sbox_share_compress.sv
// rtl/prince_sbox_share_compress.sv - glitch-barrier register plus share compression for the CMS PRINCE S-box layer
module prince_sbox_share_compress #(
  parameter int NSBOX = 16,
  parameter int NCOMP = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NSBOX*4*NCOMP-1:0] comp_in,
  input  logic [NSBOX*4-1:0]       rnd_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NSBOX*4-1:0]       out_share0,
  output logic [NSBOX*4-1:0]       out_share1
);
  import prince_cms_pkg::*;

  localparam int NBIT = NSBOX * NIBBLE;
  localparam int NCW  = NBIT * NCOMP;

  if (NCOMP != prince_cms_pkg::NCOMP) begin : g_bad_ncomp
    $error("prince_sbox_share_compress: NCOMP must be 8");
  end

  logic            s1_valid_q, s1_valid_d;
  logic [NCW-1:0]  s1_comp_q,  s1_comp_d;
  logic [NBIT-1:0] s1_rnd_q,   s1_rnd_d;
  logic            s2_valid_q, s2_valid_d;
  logic [NBIT-1:0] s2_sh0_q,   s2_sh0_d;
  logic [NBIT-1:0] s2_sh1_q,   s2_sh1_d;
  logic [NBIT-1:0] cmp_sh0, cmp_sh1;
  logic            s1_en, s2_en, s1_load, s2_load;

  // Compression sits strictly after S1, so raw components never meet before a flop.
  for (genvar s = 0; s < NSBOX; s++) begin : g_sbox
    for (genvar b = 0; b < NIBBLE; b++) begin : g_bit
      localparam int CI = comp_idx(s, b, 0);
      prince_bit_compress u_bit (
        .comp (s1_comp_q[CI +: NCOMP]),
        .r    (s1_rnd_q[s*NIBBLE+b]),
        .sh0  (cmp_sh0[s*NIBBLE+b]),
        .sh1  (cmp_sh1[s*NIBBLE+b])
      );
    end
  end

  // Stage enables and next state; data regs only move on their own load to limit share toggling.
  always_comb begin
    s2_en   = !s2_valid_q || out_ready;
    s1_en   = !s1_valid_q || s2_en;
    s1_load = in_valid && s1_en;
    s2_load = s1_valid_q && s2_en;

    s1_valid_d = s1_valid_q;
    s1_comp_d  = s1_comp_q;
    s1_rnd_d   = s1_rnd_q;
    s2_valid_d = s2_valid_q;
    s2_sh0_d   = s2_sh0_q;
    s2_sh1_d   = s2_sh1_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_comp_d  = comp_in;
      s1_rnd_d   = rnd_in;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_en) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      s2_sh0_d = cmp_sh0;
      s2_sh1_d = cmp_sh1;
    end
  end

  // Pipeline registers; reset drops any in-flight data, stalled or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_comp_q  <= '0;
      s1_rnd_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sh0_q   <= '0;
      s2_sh1_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_comp_q  <= s1_comp_d;
      s1_rnd_q   <= s1_rnd_d;
      s2_valid_q <= s2_valid_d;
      s2_sh0_q   <= s2_sh0_d;
      s2_sh1_q   <= s2_sh1_d;
    end
  end

  assign in_ready   = s1_en;
  assign out_valid  = s2_valid_q;
  assign out_share0 = s2_sh0_q;
  assign out_share1 = s2_sh1_q;

endmodule

// File: tb/tb_prince_sbox_share_compress.sv
// tb/tb_prince_sbox_share_compress.sv - scoreboard bench for the masked S-box compress stage
module tb_prince_sbox_share_compress;
  import prince_cms_pkg::*;

  localparam int NS = 16;
  localparam int NB = NS * 4;
  localparam int NC = NB * 8;

  typedef struct packed {
    logic [NB-1:0] s0;
    logic [NB-1:0] s1;
    logic [NB-1:0] ux;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NC-1:0] comp_in;
  logic [NB-1:0] rnd_in;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_share0;
  logic [NB-1:0] out_share1;

  prince_sbox_share_compress #(.NSBOX(NS), .NCOMP(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .comp_in    (comp_in),
    .rnd_in     (rnd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_share0 (out_share0),
    .out_share1 (out_share1)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  exp_t          sb_q[$];
  logic [NB-1:0] cur_x;
  int            accepts = 0;
  int            pops = 0;
  logic [NB-1:0] last0, last1;
  logic          stall_prev = 1'b0;
  logic [NB-1:0] hold0, hold1;

  // Random 8-way sharing of S(x) per nibble: 7 random components, the 8th closes the XOR.
  function automatic logic [NC-1:0] make_comp(input logic [NB-1:0] x);
    logic [NC-1:0] c;
    logic [3:0]    acc, n;
    c = '0;
    for (int s = 0; s < NS; s++) begin
      acc = sbox(x[4*s +: 4]);
      for (int k = 0; k < 8; k++) begin
        if (k < 7) begin
          n = 4'($urandom);
          acc = acc ^ n;
        end else begin
          n = acc;
        end
        for (int b = 0; b < 4; b++) c[comp_idx(s, b, k)] = n[b];
      end
    end
    return c;
  endfunction

  function automatic exp_t model(input logic [NC-1:0] c, input logic [NB-1:0] r, input logic [NB-1:0] x);
    exp_t e;
    for (int s = 0; s < NS; s++) begin
      for (int b = 0; b < 4; b++) begin
        e.s0[4*s+b] = c[comp_idx(s,b,0)] ^ c[comp_idx(s,b,1)] ^ c[comp_idx(s,b,2)] ^ c[comp_idx(s,b,3)] ^ r[4*s+b];
        e.s1[4*s+b] = c[comp_idx(s,b,4)] ^ c[comp_idx(s,b,5)] ^ c[comp_idx(s,b,6)] ^ c[comp_idx(s,b,7)] ^ r[4*s+b];
      end
      e.ux[4*s +: 4] = sbox(x[4*s +: 4]);
    end
    return e;
  endfunction

  // Monitor at the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", 64'(out_valid), 64'd1);
        check_eq("hold_sh0", out_share0, hold0);
        check_eq("hold_sh1", out_share1, hold1);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sh0", out_share0, e.s0);
          check_eq("sh1", out_share1, e.s1);
          check_eq("unmask", out_share0 ^ out_share1, e.ux);
        end
        last0 = out_share0;
        last1 = out_share1;
        pops++;
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(comp_in, rnd_in, cur_x));
        accepts++;
      end
      stall_prev = out_valid && !out_ready;
      hold0 = out_share0;
      hold1 = out_share1;
    end
  end

  task automatic drive(input logic [NB-1:0] x, input logic [NC-1:0] c, input logic [NB-1:0] r);
    cur_x    = x;
    comp_in  = c;
    rnd_in   = r;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [NB-1:0] x, input logic [NC-1:0] c, input logic [NB-1:0] r);
    int a0;
    a0 = accepts;
    drive(x, c, r);
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (accepts != a0) break;
    end
    in_valid = 1'b0;
    check_eq("send_accept", 64'(accepts - a0), 64'd1);
  endtask

  task automatic wait_pops(input int target);
    for (int t = 0; t < 100 && pops < target; t++) begin
      @(posedge clk); #1;
    end
    check_eq("pop_wait", 64'(pops >= target), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check_eq("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    logic [NC-1:0] cfix;
    logic [NB-1:0] r0_sh0, r0_sh1;
    int a0, p0, issued, guard;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    comp_in = '0; rnd_in = '0; cur_x = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sh0", out_share0, 64'd0);
    check_eq("rst_sh1", out_share1, 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency and unmasking for x = 0, 7, F in every nibble.
    send(64'h0, make_comp(64'h0), {NB{1'b1}});
    check_eq("lat_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq("lat_cycle2", 64'(out_valid), 64'd1);
    wait_pops(1);
    check_eq("unmask_x0", last0 ^ last1, 64'hBBBB_BBBB_BBBB_BBBB);
    send(64'h7777_7777_7777_7777, make_comp(64'h7777_7777_7777_7777), 64'h0);
    wait_pops(2);
    check_eq("unmask_x7", last0 ^ last1, 64'h1111_1111_1111_1111);
    send({NB{1'b1}}, make_comp({NB{1'b1}}), 64'h0);
    wait_pops(3);
    check_eq("unmask_xf", last0 ^ last1, 64'h4444_4444_4444_4444);

    // Refresh: identical components, opposite randomness.
    cfix = make_comp(64'h0123_4567_89AB_CDEF);
    send(64'h0123_4567_89AB_CDEF, cfix, 64'h0);
    wait_pops(4);
    r0_sh0 = last0; r0_sh1 = last1;
    send(64'h0123_4567_89AB_CDEF, cfix, {NB{1'b1}});
    wait_pops(5);
    check_eq("refresh_diff", r0_sh0 ^ last0, {NB{1'b1}});
    check_eq("refresh_xor", r0_sh0 ^ r0_sh1, last0 ^ last1);

    // Back-to-back stream x = 0..F, no bubbles on either side.
    a0 = accepts; p0 = pops;
    for (int i = 0; i < 16; i++) begin
      drive({16{4'(i)}}, make_comp({16{4'(i)}}), {$urandom, $urandom});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("stream_accepts", 64'(accepts - a0), 64'd16);
    check_eq("stream_beats", 64'(pops - p0), 64'd16);
    drain();

    // Backpressure: five stalled cycles while streaming.
    out_ready = 1'b0;
    a0 = accepts; p0 = pops; issued = 0;
    for (int t = 0; t < 5; t++) begin
      if (!in_valid || accepts != a0 + issued - 1) begin
        drive({$urandom, $urandom}, '0, {$urandom, $urandom});
        comp_in = make_comp(cur_x);
        issued++;
      end
      @(posedge clk); #1;
    end
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_accepts", 64'(accepts - a0), 64'd2);
    check_eq("bp_no_pop", 64'(pops - p0), 64'd0);
    out_ready = 1'b1;
    for (int t = 0; t < 50 && (accepts - a0) < 3; t++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check_eq("bp_total", 64'(pops - p0), 64'(accepts - a0));

    // Reset while both stages are full and stalled.
    out_ready = 1'b0;
    send(64'hAAAA_5555_AAAA_5555, make_comp(64'hAAAA_5555_AAAA_5555), 64'h0);
    send(64'h1234_1234_1234_1234, make_comp(64'h1234_1234_1234_1234), 64'h0);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_sh0", out_share0, 64'd0);
    check_eq("mid_rst_sh1", out_share1, 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    p0 = pops;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("mid_rst_no_old", 64'(pops - p0), 64'd0);

    // Random regression with random backpressure.
    a0 = accepts; issued = 0; guard = 0;
    in_valid = 1'b0;
    while ((accepts - a0) < 10000 && guard < 60000) begin
      if (in_valid && accepts - a0 == issued) in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && issued < 10000 && $urandom_range(0, 7) != 0) begin
        drive({$urandom, $urandom}, '0, {$urandom, $urandom});
        comp_in = make_comp(cur_x);
        issued++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check_eq("rand_accepts", 64'(accepts - a0), 64'd10000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prince_sbox_share_compress.md
Name: prince_sbox_share_compress

Overview:
- Register-and-compress back end for the first-order CMS-masked PRINCE S-box layer.
- Consumes the 8 nonlinear component shares per output bit (sh1..sh8) produced by the per-bit share functions.
- Registers them as a glitch barrier, then compresses and refreshes them back to a 2-share output nibble.
- Sits between the S-box component-function array and the linear layer, with a valid/ready pipeline.

Parameters:
- NSBOX, 16, number of parallel 4-bit S-boxes handled (16 = full 64-bit PRINCE state).
- NCOMP, 8, component shares per output bit; fixed at 8, any other value is a synthesis-time error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  component shares and randomness valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- comp_in  input  NSBOX*4*NCOMP  component shares; bit index ((s*4+b)*NCOMP+k) is S-box s, output bit b (0..3, bit4 -> b=3), component sh(k+1).
- rnd_in  input  NSBOX*4  fresh randomness, one bit per output bit; sampled together with comp_in.
- out_valid  output  1  out_share0/out_share1 valid.
- out_ready  input  1  downstream accepts the output.
- out_share0  output  NSBOX*4  output share 0, nibble s at bits [4s+3:4s].
- out_share1  output  NSBOX*4  output share 1.

Behaviour:
- Two register stages:
  - S1 holds raw comp_in plus rnd_in, with no logic before the registers.
  - S2 holds the compressed and refreshed shares.
- Latency is 2 cycles from accepted input to out_valid with out_ready held high.
- Throughput is 1 nibble-set per cycle.
- Security rule: no combinational path may combine component shares before the S1 flops. comp_in goes straight to D pins.
- Compression is per S-box s and bit b, computed from S1 contents:
  - out_share0 = sh1^sh2^sh3^sh4^r
  - out_share1 = sh5^sh6^sh7^sh8^r
  - The result goes into S2.
- Invariant: out_share0 ^ out_share1 = XOR of all 8 components, which is the unmasked S-box output bit.
- Handshake, standard valid/ready per stage:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en (combinational from out_ready and the stage valids only, never from data).
- S1 loads on in_valid & in_ready. s1_valid is set by that load and cleared when S1 moves to S2 with no new load.
- S2 loads when s1_valid & s2_en. out_valid = s2_valid.
- While out_valid & !out_ready:
  - out_share0/1 hold stable.
  - out_valid stays high.
  - S1 keeps its content if occupied.
- Simultaneous events:
  - S2 drains while S1 moves and a new input loads in the same cycle; all three happen, no bubble.
  - When both stages are full and out_ready=0: in_ready=0, and inputs are ignored (not captured).
- Reset, synchronous, on any edge with rst=1:
  - s1_valid, s2_valid and out_valid go to 0.
  - out_share0 and out_share1 go to 0.
  - S1 data regs go to 0.
  - In-flight data is discarded, including mid-stall.
  - in_ready=1 in the first cycle after rst deasserts.
- Share data regs update only on their stage enable, to avoid needless share toggling.

Decomposition:
- Package prince_cms_pkg holds:
  - NCOMP.
  - The NIBBLE width constant.
  - The group split constant: components 0..3 go to share 0, 4..7 go to share 1.
  - The function comp_idx(s, b, k).
  - The PRINCE S-box table, for bench use only.
- One sub-module: prince_bit_compress. It compresses one output bit: 8 registered components plus r in, 2 shares out, combinational only. The top generates NSBOX*4 instances of it between S1 and S2.

Test Plan:
- Unmask check, NSBOX=1: x=0x0 shared as (0x5,0x5), components from the bench model, rnd=0xF, out_ready=1 -> after 2 cycles out_valid=1 and out_share0^out_share1=0xB. Also x=0x7 -> 0x1 and x=0xF -> 0x4.
- Refresh check: same components, rnd 0x0 vs 0xF -> out_share0 differs by 0xF, XOR of shares unchanged.
- Streaming: in_valid=1 for 16 cycles with x=0..F, out_ready=1 -> 16 consecutive out_valid beats giving B,F,3,2,A,C,9,1,6,7,8,0,E,5,D,4, no bubbles.
- Backpressure: out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepted beats, outputs hold stable, no loss or duplication after release.
- Reset mid-stall: both stages full, rst=1 one cycle -> out_valid=0, shares=0, in_ready=1 next cycle, old data never appears.
- NSBOX=16 random regression: 10k random inputs with random out_ready -> XOR of shares equals S(x) for every nibble, in order.
